corr_filter: RTL and testbench
==============================

CORR_FILTER -- requirements
Module: corr_filter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, output buffer entries (power of 2, >=4).
REQ-002 SHALL have ports: i_clk  in  1  single clock, rising edge.
REQ-003 i_rst_n  in  1  reset; asynchronous assert, active-low.
REQ-004 i_frame_start, i_frame_end, i_valid  in  1 each  frame markers and correspondence strobe from the correspondence-calculation stage.
REQ-005 i_idx0_x/i_idx1_x  in  H_SIZE_BW; i_idx0_y/i_idx1_y  in  V_SIZE_BW  source and projected pixel indices.
REQ-006 i_trans_z0  in  CLOUD_BW  transformed depth, signed two's complement.
REQ-007 r_hsize  in  H_SIZE_BW; r_vsize  in  V_SIZE_BW  image size registers.
REQ-008 o_valid  out  1; i_ready  in  1  downstream valid/ready handshake.
REQ-009 o_idx0_x, o_idx0_y, o_idx1_x, o_idx1_y, o_trans_z0  out  same widths as inputs  buffered correspondence.
REQ-010 o_corr_cnt  out  H_SIZE_BW+V_SIZE_BW  accepted correspondences this frame.
REQ-011 o_frame_done  out  1  one-cycle pulse at frame completion.
REQ-012 o_overflow, o_seq_err  out  1 each  sticky error flags.

Function
REQ-013 Correspondence passes iff i_valid, i_idx1_x<r_hsize, i_idx1_y<r_vsize, i_trans_z0>0 (MSB 0, nonzero), and state is ACTIVE or i_frame_start accepted same cycle.
REQ-014 Filter result and fields SHALL be registered 1 cycle, then written to FIFO; o_valid first asserts 2 cycles after passing i_valid when FIFO empty and i_ready high.
REQ-015 FIFO SHALL be first-word-fall-through; entry pops when o_valid && i_ready; o_* fields stable while o_valid && !i_ready.
REQ-016 FSM states IDLE, ACTIVE, DRAIN; IDLE->ACTIVE on i_frame_start; ACTIVE->DRAIN on i_frame_end; DRAIN->IDLE when pipeline register empty and FIFO empty, asserting o_frame_done that cycle.
REQ-017 i_valid coincident with i_frame_end SHALL be processed as last item of frame.
REQ-018 i_frame_start in ACTIVE or DRAIN SHALL be ignored and set o_seq_err; i_frame_end in IDLE SHALL be ignored and set o_seq_err.
REQ-019 i_frame_start and i_frame_end same cycle in IDLE: single-pixel frame, go ACTIVE then DRAIN next cycle.
REQ-020 Push to full FIFO SHALL drop the entry and set o_overflow, unless a pop occurs same cycle, in which case push succeeds.
REQ-021 o_corr_cnt SHALL clear on accepted i_frame_start, increment per successful FIFO write, saturate at all-ones, hold value through IDLE.
REQ-022 Dropped entries SHALL NOT increment o_corr_cnt.
REQ-023 Failing correspondences SHALL be discarded silently.

Reset
REQ-024 On i_rst_n low: FSM IDLE, FIFO empty, pipeline register invalid, o_valid 0, o_frame_done 0, o_corr_cnt 0, o_overflow 0, o_seq_err 0, o_* data 0.
REQ-025 Reset mid-frame SHALL discard all buffered entries; first i_frame_start after release starts clean frame.
REQ-026 o_overflow and o_seq_err SHALL clear only on reset or accepted i_frame_start.

Configuration
REQ-027 Macro CORR_FILTER_ZMIN_EN defined: add input r_zmin (CLOUD_BW, unsigned) and REQ-013 depth condition becomes i_trans_z0>0 and i_trans_z0>=r_zmin.
REQ-028 Macro undefined: r_zmin port absent; depth condition is i_trans_z0>0 only.

Verification
REQ-029 start, 3 valid items idx1=(10,5),(640,5),(10,5) z=100, r_hsize=640, r_vsize=480, i_ready=1 -> 2 outputs, o_corr_cnt=2, o_frame_done after drain.
REQ-030 i_trans_z0=0 and i_trans_z0=-1 (all-ones) items -> no output, o_corr_cnt=0.
REQ-031 i_ready=0, 20 passing items, FIFO_DEPTH=16 -> o_overflow=1, o_corr_cnt=17 (16 FIFO + 1 pipeline reg), first 16 popped in order after i_ready=1.
REQ-032 i_frame_start during ACTIVE -> o_seq_err=1, o_corr_cnt not cleared; next accepted start clears both flags.
REQ-033 reset asserted with 5 entries buffered -> o_valid=0 immediately, o_corr_cnt=0, FSM IDLE.
REQ-034 CORR_FILTER_ZMIN_EN, r_zmin=500, z=499 and 500 -> only z=500 item output.

Source files
------------

// File: rtl/corr_filter_if.sv
// Downstream correspondence stream of corr_filter: FWFT output fields with
// valid/ready handshake. master = corr_filter side, slave = consumer side.
interface corr_filter_if #(
    parameter int unsigned H_SIZE_BW = 11,
    parameter int unsigned V_SIZE_BW = 10,
    parameter int unsigned CLOUD_BW  = 16
) ();
    logic                 o_valid;
    logic                 i_ready;
    logic [H_SIZE_BW-1:0] o_idx0_x;
    logic [V_SIZE_BW-1:0] o_idx0_y;
    logic [H_SIZE_BW-1:0] o_idx1_x;
    logic [V_SIZE_BW-1:0] o_idx1_y;
    logic [CLOUD_BW-1:0]  o_trans_z0;

    modport master (
        output o_valid, o_idx0_x, o_idx0_y, o_idx1_x, o_idx1_y, o_trans_z0,
        input  i_ready
    );

    modport slave (
        input  o_valid, o_idx0_x, o_idx0_y, o_idx1_x, o_idx1_y, o_trans_z0,
        output i_ready
    );
endinterface

// File: rtl/corr_filter.sv
// Correspondence filter: range/depth check, one register stage, FWFT output FIFO,
// frame FSM and counters. Define CORR_FILTER_ZMIN_EN to add the r_zmin depth floor.
module corr_filter #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned H_SIZE_BW  = 11,
    parameter int unsigned V_SIZE_BW  = 10,
    parameter int unsigned CLOUD_BW   = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_frame_start,
    input  logic                           i_frame_end,
    input  logic                           i_valid,
    input  logic [H_SIZE_BW-1:0]           i_idx0_x,
    input  logic [V_SIZE_BW-1:0]           i_idx0_y,
    input  logic [H_SIZE_BW-1:0]           i_idx1_x,
    input  logic [V_SIZE_BW-1:0]           i_idx1_y,
    input  logic [CLOUD_BW-1:0]            i_trans_z0,
    input  logic [H_SIZE_BW-1:0]           r_hsize,
    input  logic [V_SIZE_BW-1:0]           r_vsize,
`ifdef CORR_FILTER_ZMIN_EN
    input  logic [CLOUD_BW-1:0]            r_zmin,
`endif
    corr_filter_if.master                  dn,
    output logic [H_SIZE_BW+V_SIZE_BW-1:0] o_corr_cnt,
    output logic                           o_frame_done,
    output logic                           o_overflow,
    output logic                           o_seq_err
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned DW = 2*H_SIZE_BW + 2*V_SIZE_BW + CLOUD_BW;
    localparam int unsigned CW = H_SIZE_BW + V_SIZE_BW;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          end_pend_q, end_pend_d;
    logic          pipe_vld_q, pipe_vld_d;
    logic [DW-1:0] pipe_data_q, pipe_data_d;
    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d, seq_q, seq_d;

    logic [AW:0]   fill;
    logic          fifo_empty, fifo_full, pop, push;
    logic          start_acc, depth_ok, pass, pipe_load, done;
    logic [DW-1:0] head;

    assign fill       = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == (AW+1)'(FIFO_DEPTH));
    assign pop        = !fifo_empty && dn.i_ready;
    assign push       = pipe_vld_q && (!fifo_full || pop);

    assign start_acc  = i_frame_start && (state_q == IDLE);
`ifdef CORR_FILTER_ZMIN_EN
    assign depth_ok   = !i_trans_z0[CLOUD_BW-1] && (|i_trans_z0) && (i_trans_z0 >= r_zmin);
`else
    assign depth_ok   = !i_trans_z0[CLOUD_BW-1] && (|i_trans_z0);
`endif
    assign pass       = i_valid && (i_idx1_x < r_hsize) && (i_idx1_y < r_vsize) && depth_ok
                        && ((state_q == ACTIVE) || start_acc);
    // The register stage stalls behind a full FIFO, so it counts as one extra buffer slot.
    assign pipe_load  = pass && (!pipe_vld_q || push);
    assign done       = (state_q == DRAIN) && !pipe_vld_q && fifo_empty;

    always_comb begin
        state_d     = state_q;
        end_pend_d  = 1'b0;
        seq_d       = start_acc ? 1'b0 : seq_q;
        ovf_d       = start_acc ? 1'b0 : ovf_q;
        cnt_d       = start_acc ? '0 : cnt_q;
        pipe_vld_d  = pipe_load || (pipe_vld_q && !push);
        pipe_data_d = pipe_load ? {i_idx0_x, i_idx0_y, i_idx1_x, i_idx1_y, i_trans_z0}
                                : pipe_data_q;
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case (state_q)
            IDLE: begin
                if (i_frame_start) begin
                    state_d    = ACTIVE;
                    end_pend_d = i_frame_end;
                end else if (i_frame_end) begin
                    seq_d = 1'b1;
                end
            end
            ACTIVE: begin
                if (i_frame_start) seq_d = 1'b1;
                if (i_frame_end || end_pend_q) state_d = DRAIN;
            end
            DRAIN: begin
                if (i_frame_start) seq_d = 1'b1;
                if (done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (pass && !pipe_load) ovf_d = 1'b1;
        if (pipe_load && (cnt_d != '1)) cnt_d = cnt_d + CW'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            end_pend_q  <= 1'b0;
            pipe_vld_q  <= 1'b0;
            pipe_data_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            seq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            end_pend_q  <= end_pend_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_data_q <= pipe_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            seq_q       <= seq_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= pipe_data_q;
    end

    // Storage is not reset; masking the head keeps the data outputs zero while empty.
    assign head = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    assign dn.o_valid = !fifo_empty;
    assign {dn.o_idx0_x, dn.o_idx0_y, dn.o_idx1_x, dn.o_idx1_y, dn.o_trans_z0} = head;

    assign o_corr_cnt   = cnt_q;
    assign o_frame_done = done;
    assign o_overflow   = ovf_q;
    assign o_seq_err    = seq_q;
endmodule

// File: tb/tb_corr_filter.sv
// Directed-vector bench for corr_filter; expected entries are queued at stimulus
// time and a negedge monitor pops them on every accepted output transfer.
module tb_corr_filter;
    localparam int unsigned HB = 11;
    localparam int unsigned VB = 10;
    localparam int unsigned CB = 16;
    localparam int unsigned DW = 2*HB + 2*VB + CB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_frame_start, i_frame_end, i_valid;
    logic [HB-1:0] i_idx0_x, i_idx1_x;
    logic [VB-1:0] i_idx0_y, i_idx1_y;
    logic [CB-1:0] i_trans_z0;
    logic [HB-1:0] r_hsize;
    logic [VB-1:0] r_vsize;
`ifdef CORR_FILTER_ZMIN_EN
    logic [CB-1:0] r_zmin;
`endif
    logic [HB+VB-1:0] o_corr_cnt;
    logic          o_frame_done, o_overflow, o_seq_err;

    int checks = 0;
    int errors = 0;
    int tag    = 1;
    logic [DW-1:0] exp_q [$];

    corr_filter_if #(.H_SIZE_BW(HB), .V_SIZE_BW(VB), .CLOUD_BW(CB)) dn ();

    corr_filter #(.FIFO_DEPTH(16), .H_SIZE_BW(HB), .V_SIZE_BW(VB), .CLOUD_BW(CB)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_frame_start(i_frame_start), .i_frame_end(i_frame_end), .i_valid(i_valid),
        .i_idx0_x(i_idx0_x), .i_idx0_y(i_idx0_y), .i_idx1_x(i_idx1_x), .i_idx1_y(i_idx1_y),
        .i_trans_z0(i_trans_z0), .r_hsize(r_hsize), .r_vsize(r_vsize),
`ifdef CORR_FILTER_ZMIN_EN
        .r_zmin(r_zmin),
`endif
        .dn(dn), .o_corr_cnt(o_corr_cnt), .o_frame_done(o_frame_done),
        .o_overflow(o_overflow), .o_seq_err(o_seq_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && dn.o_valid && dn.i_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out got %0h expected none",
                         {dn.o_idx0_x, dn.o_idx0_y, dn.o_idx1_x, dn.o_idx1_y, dn.o_trans_z0});
            end else begin
                logic [DW-1:0] e, a;
                e = exp_q.pop_front();
                a = {dn.o_idx0_x, dn.o_idx0_y, dn.o_idx1_x, dn.o_idx1_y, dn.o_trans_z0};
                if (a !== e) begin
                    errors++;
                    $display("FAIL out_data got %0h expected %0h", a, e);
                end
            end
        end
    end

    // One input cycle; the strobes are pulses and drop after the sampling edge.
    task automatic drive(input bit fs, input bit fe, input bit v, input logic [HB-1:0] x1,
                         input logic [VB-1:0] y1, input logic [CB-1:0] z, input bit exp);
        i_frame_start = fs;
        i_frame_end   = fe;
        i_valid       = v;
        i_idx0_x      = HB'(tag);
        i_idx0_y      = VB'(tag * 3);
        i_idx1_x      = x1;
        i_idx1_y      = y1;
        i_trans_z0    = z;
        if (exp) exp_q.push_back({HB'(tag), VB'(tag * 3), x1, y1, z});
        tag++;
        @(posedge clk); #1;
        i_frame_start = 1'b0;
        i_frame_end   = 1'b0;
        i_valid       = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (o_frame_done) seen = 1'b1;
        end
        chk("frame_done", 64'(seen), 64'd1);
        @(negedge clk);
        chk("done_pulse", 64'(o_frame_done), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_tag;
        rst_n = 1'b0;
        i_frame_start = 1'b0; i_frame_end = 1'b0; i_valid = 1'b0;
        i_idx0_x = '0; i_idx0_y = '0; i_idx1_x = '0; i_idx1_y = '0; i_trans_z0 = '0;
        r_hsize = 11'd640; r_vsize = 10'd480;
`ifdef CORR_FILTER_ZMIN_EN
        r_zmin = '0;
`endif
        dn.i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(dn.o_valid), 0);
        chk("rst_cnt",   64'(o_corr_cnt), 0);
        chk("rst_ovf",   64'(o_overflow), 0);
        chk("rst_seq",   64'(o_seq_err), 0);
        chk("rst_done",  64'(o_frame_done), 0);
        chk("rst_data",  64'({dn.o_idx0_x, dn.o_trans_z0}), 0);
        rst_n = 1'b1;
        idle(1);

        // Basic frame: x=640 is out of range; the end-coincident item is the last one.
        drive(1, 0, 1, 11'd10,  10'd5, 16'd100, 1);
        chk("lat_1cyc", 64'(dn.o_valid), 0);
        drive(0, 0, 1, 11'd640, 10'd5, 16'd100, 0);
        chk("lat_2cyc", 64'(dn.o_valid), 1);
        drive(0, 1, 1, 11'd10,  10'd5, 16'd100, 1);
        wait_done(20);
        chk("cnt_basic", 64'(o_corr_cnt), 2);
        chk("seq_basic", 64'(o_seq_err), 0);

        // Depth sign/zero rejection, end in IDLE, valid in IDLE.
        drive(0, 1, 0, 11'd0, 10'd0, 16'd0, 0);
        chk("seq_end_idle", 64'(o_seq_err), 1);
        drive(0, 0, 1, 11'd10, 10'd5, 16'd100, 0);
        drive(1, 0, 1, 11'd10, 10'd5, 16'd0, 0);
        chk("seq_clr_start", 64'(o_seq_err), 0);
        drive(0, 0, 1, 11'd10, 10'd5, 16'hFFFF, 0);
        drive(0, 1, 0, 11'd0,  10'd0, 16'd0, 0);
        wait_done(20);
        chk("cnt_zneg", 64'(o_corr_cnt), 0);

        // Range edges.
        drive(1, 0, 1, 11'd639, 10'd479, 16'd1, 1);
        drive(0, 0, 1, 11'd10,  10'd480, 16'd100, 0);
        drive(0, 0, 1, 11'd10,  10'd5,   16'h8000, 0);
        drive(0, 1, 1, 11'd5,   10'd5,   16'h7FFF, 1);
        wait_done(20);
        chk("cnt_edges", 64'(o_corr_cnt), 2);

        // Single-pixel frame.
        drive(1, 1, 1, 11'd1, 10'd1, 16'd50, 1);
        wait_done(20);
        chk("cnt_single", 64'(o_corr_cnt), 1);
        chk("seq_single", 64'(o_seq_err), 0);

        // Start while ACTIVE.
        drive(1, 0, 1, 11'd20, 10'd20, 16'd200, 1);
        drive(1, 0, 0, 11'd0,  10'd0,  16'd0, 0);
        chk("seq_restart", 64'(o_seq_err), 1);
        chk("cnt_restart", 64'(o_corr_cnt), 1);
        drive(0, 1, 0, 11'd0, 10'd0, 16'd0, 0);
        wait_done(20);
        chk("seq_sticky", 64'(o_seq_err), 1);
        drive(1, 0, 0, 11'd0, 10'd0, 16'd0, 0);
        chk("seq_clr", 64'(o_seq_err), 0);
        chk("cnt_clr", 64'(o_corr_cnt), 0);
        drive(0, 1, 0, 11'd0, 10'd0, 16'd0, 0);
        wait_done(20);

        // Overflow: 16 in FIFO + 1 held in the register stage, last 3 dropped.
        dn.i_ready = 1'b0;
        first_tag = tag;
        for (int i = 0; i < 20; i++)
            drive(i == 0, i == 19, 1, 11'(i + 30), 10'(i + 7), 16'(i + 300), i < 17);
        idle(2);
        chk("ovf_flag", 64'(o_overflow), 1);
        chk("ovf_cnt",  64'(o_corr_cnt), 17);
        chk("ovf_head", 64'(dn.o_idx0_x), 64'(HB'(first_tag)));
        idle(1);
        chk("ovf_hold", 64'(dn.o_idx0_x), 64'(HB'(first_tag)));
        dn.i_ready = 1'b1;
        wait_done(60);
        chk("ovf_sticky", 64'(o_overflow), 1);

        // Start clears overflow; then reset with 5 entries buffered.
        dn.i_ready = 1'b0;
        drive(1, 0, 0, 11'd0, 10'd0, 16'd0, 0);
        chk("ovf_clr", 64'(o_overflow), 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 11'(i + 2), 10'(i + 2), 16'd77, 0);
        idle(3);
        chk("pre_rst_valid", 64'(dn.o_valid), 1);
        chk("pre_rst_cnt",   64'(o_corr_cnt), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(dn.o_valid), 0);
        chk("mid_rst_cnt",   64'(o_corr_cnt), 0);
        chk("mid_rst_data",  64'(dn.o_idx0_x), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dn.i_ready = 1'b1;
        drive(0, 1, 0, 11'd0, 10'd0, 16'd0, 0);
        chk("rst_idle_seq", 64'(o_seq_err), 1);
        drive(1, 1, 1, 11'd3, 10'd4, 16'd9, 1);
        wait_done(20);
        chk("post_rst_cnt", 64'(o_corr_cnt), 1);
        chk("post_rst_seq", 64'(o_seq_err), 0);

`ifdef CORR_FILTER_ZMIN_EN
        r_zmin = 16'd500;
        drive(1, 0, 1, 11'd10, 10'd5, 16'd499, 0);
        drive(0, 1, 1, 11'd10, 10'd5, 16'd500, 1);
        wait_done(20);
        chk("zmin_cnt", 64'(o_corr_cnt), 1);
`endif

        idle(3);
        chk("sb_empty", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
